// File: rtl/vtx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vtx_pkg                                                            |
// | Shared constants and types for the vertex transform front end.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package vtx_pkg;

  localparam int unsigned FRAC_BITS     = 16;
  localparam logic [31:0] ONE_FX        = 32'(1) << FRAC_BITS;
  localparam int unsigned WORDS_PER_TRI = 15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_PRESENT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Word order of one assembled triangle in vertex memory and on v_out
  typedef enum logic [3:0] {
    X1 = 4'd0,  Y1 = 4'd1,  Z1 = 4'd2,  RGB1 = 4'd3,
    X2 = 4'd4,  Y2 = 4'd5,  Z2 = 4'd6,  RGB2 = 4'd7,
    X3 = 4'd8,  Y3 = 4'd9,  Z3 = 4'd10, RGB3 = 4'd11,
    NX = 4'd12, NY = 4'd13, NZ = 4'd14
  } vtx_word_e;

endpackage
`default_nettype wire

// File: rtl/vtx_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vtx_sequencer                                                      |
// | Holds the transform matrix, fetches triangle lists from vertex     |
// | memory and presents each triangle under a valid/stall handshake.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module vtx_sequencer
  import vtx_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mat_we,
  input  logic [3:0]        mat_addr,
  input  logic [31:0]       mat_wdata,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       tri_count,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [511:0]      mat,
  output logic [479:0]      v_out,
  output logic              v_valid,
  input  logic              stall_in,
  output logic              busy,
  output logic              done
);

  localparam logic [3:0] c_NUM_WORDS = 4'(WORDS_PER_TRI);
  localparam logic [3:0] c_LAST_WORD = 4'(NZ);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_issue_cnt;
  logic [3:0]        r_cap_cnt;
  logic              r_rd_q;
  logic [15:0]       r_tri_idx;
  logic [15:0]       r_tri_count;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_v_out [WORDS_PER_TRI];
  logic [31:0]       r_mat   [16];
  logic              w_hs;
  logic              w_last_cap;
  logic              w_last_tri;
  logic              w_idle;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_hs       = v_valid && !stall_in;
  assign w_last_cap = r_rd_q && (r_cap_cnt == c_LAST_WORD);
  assign w_last_tri = (r_tri_idx == r_tri_count - 16'd1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_state_nxt = (tri_count == 16'd0) ? ST_DONE : ST_FETCH;
      ST_FETCH:   if (w_last_cap) w_state_nxt = ST_PRESENT;
      ST_PRESENT: if (w_hs) w_state_nxt = w_last_tri ? ST_DONE : ST_FETCH;
      ST_DONE:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en = 1'b0;
    v_valid   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (r_state)
      ST_IDLE:    busy      = 1'b0;
      ST_FETCH:   mem_rd_en = (r_issue_cnt != c_NUM_WORDS);
      ST_PRESENT: v_valid   = 1'b1;
      ST_DONE:    done      = 1'b1;
      default:    busy      = 1'b0;
    endcase
  end

  // Read data lands one cycle after its strobe; r_rd_q marks that cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_q      <= 1'b0;
      r_issue_cnt <= '0;
      r_cap_cnt   <= '0;
      r_tri_idx   <= '0;
      r_tri_count <= '0;
      r_mem_addr  <= '0;
      for (int i = 0; i < int'(WORDS_PER_TRI); i++) r_v_out[i] <= '0;
    end else begin
      r_rd_q <= mem_rd_en;
      if (w_idle && start) begin
        r_mem_addr  <= base_addr;
        r_tri_count <= tri_count;
        r_tri_idx   <= '0;
      end
      if (mem_rd_en) begin
        r_mem_addr  <= r_mem_addr + ADDR_W'(1);
        r_issue_cnt <= r_issue_cnt + 4'd1;
      end
      if (r_rd_q) begin
        r_v_out[r_cap_cnt] <= mem_rdata;
        r_cap_cnt          <= r_cap_cnt + 4'd1;
      end
      if (r_state != ST_FETCH) begin
        r_issue_cnt <= '0;
        r_cap_cnt   <= '0;
      end
      if (w_hs) r_tri_idx <= r_tri_idx + 16'd1;
    end
  end

  // Matrix is only writable while idle so a run sees one consistent transform.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) r_mat[i] <= (i % 5 == 0) ? ONE_FX : 32'd0;
    end else if (w_idle && mat_we) begin
      r_mat[mat_addr] <= mat_wdata;
    end
  end

  assign mem_addr = r_mem_addr;

  for (genvar g = 0; g < 16; g++) begin : g_mat
    assign mat[32*g +: 32] = r_mat[g];
  end

  for (genvar g = 0; g < int'(WORDS_PER_TRI); g++) begin : g_vout
    assign v_out[32*g +: 32] = r_v_out[g];
  end

endmodule
`default_nettype wire
